// File: rtl/ansi_key_encoder.sv
// Keyboard-to-UART encoder: turns scanner key codes into single bytes or
// VT100/ANSI escape sequences, streamed one byte per TX handshake.
module ansi_key_encoder #(
    parameter logic [7:0] ESC_CODE      = 8'h1B,
    parameter bit         DROP_UNMAPPED = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyValid,
    input  logic [7:0] keyCode,
    output logic       keyReady,
    input  logic       decckm,
    input  logic       lnm,
    input  logic       txReady,
    output logic       txDataOutValid,
    output logic [7:0] txDataOut,
    output logic       keyDropped,
    output logic       busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [2:0][7:0]   seq_q, seq_d;        // bytes still pending after the current one
    logic [2:0]        cnt_q, cnt_d;        // bytes remaining including the current one
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              key_dropped_q, key_dropped_d;
    logic              busy_q, busy_d;

    logic [3:0][7:0]   map_seq;
    logic [2:0]        map_len;
    logic              map_drop;
    logic [7:0]        intro;
    logic              accept;
    logic              handshake;

    assign keyReady  = (state_q == IDLE) && !reset;
    assign accept    = keyValid && keyReady;
    assign handshake = tx_valid_q && txReady;

    // Cursor and home/end keys switch between CSI and SS3 with DECCKM.
    assign intro = decckm ? 8'h4F : 8'h5B;

    always_comb begin
        map_seq  = '0;
        map_len  = 3'd1;
        map_drop = 1'b0;
        map_seq[0] = keyCode;
        if (!keyCode[7]) begin
            if (keyCode == 8'h0D && lnm) begin
                map_len    = 3'd2;
                map_seq[1] = 8'h0A;
            end
        end else begin
            case (keyCode)
                8'h80: begin map_len = 3'd3; map_seq = {8'h00, 8'h41, intro, ESC_CODE}; end
                8'h81: begin map_len = 3'd3; map_seq = {8'h00, 8'h42, intro, ESC_CODE}; end
                8'h82: begin map_len = 3'd3; map_seq = {8'h00, 8'h43, intro, ESC_CODE}; end
                8'h83: begin map_len = 3'd3; map_seq = {8'h00, 8'h44, intro, ESC_CODE}; end
                8'h84: begin map_len = 3'd3; map_seq = {8'h00, 8'h48, intro, ESC_CODE}; end
                8'h85: begin map_len = 3'd3; map_seq = {8'h00, 8'h46, intro, ESC_CODE}; end
                8'h86: begin map_len = 3'd4; map_seq = {8'h7E, 8'h32, 8'h5B, ESC_CODE}; end
                8'h87: begin map_len = 3'd4; map_seq = {8'h7E, 8'h33, 8'h5B, ESC_CODE}; end
                8'h88: begin map_len = 3'd4; map_seq = {8'h7E, 8'h35, 8'h5B, ESC_CODE}; end
                8'h89: begin map_len = 3'd4; map_seq = {8'h7E, 8'h36, 8'h5B, ESC_CODE}; end
                8'h8A: begin map_len = 3'd3; map_seq = {8'h00, 8'h50, 8'h4F, ESC_CODE}; end
                8'h8B: begin map_len = 3'd3; map_seq = {8'h00, 8'h51, 8'h4F, ESC_CODE}; end
                8'h8C: begin map_len = 3'd3; map_seq = {8'h00, 8'h52, 8'h4F, ESC_CODE}; end
                8'h8D: begin map_len = 3'd3; map_seq = {8'h00, 8'h53, 8'h4F, ESC_CODE}; end
                default: map_drop = DROP_UNMAPPED;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        busy_d        = busy_q;
        key_dropped_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (map_drop) begin
                        key_dropped_d = 1'b1;
                    end else begin
                        state_d    = SEND;
                        seq_d      = map_seq[3:1];
                        cnt_d      = map_len;
                        tx_data_d  = map_seq[0];
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            SEND: begin
                if (handshake) begin
                    if (cnt_q == 3'd1) begin
                        state_d    = IDLE;
                        seq_d      = '0;
                        cnt_d      = 3'd0;
                        tx_data_d  = 8'h00;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                    end else begin
                        seq_d     = {8'h00, seq_q[2:1]};
                        cnt_d     = cnt_q - 3'd1;
                        tx_data_d = seq_q[0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            seq_q         <= '0;
            cnt_q         <= 3'd0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            key_dropped_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            key_dropped_q <= key_dropped_d;
            busy_q        <= busy_d;
        end
    end

    assign txDataOutValid = tx_valid_q;
    assign txDataOut      = tx_data_q;
    assign keyDropped     = key_dropped_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ansi_key_encoder.sv
// Self-checking bench for ansi_key_encoder: directed steps followed by random
// keys, each checked byte-by-byte against a table-driven reference model.
module tb_ansi_key_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       keyValid, decckm, lnm, txReady;
    logic [7:0] keyCode;
    logic       keyReady, txDataOutValid, keyDropped, busy;
    logic [7:0] txDataOut;

    logic       key_valid0, tx_ready0;
    logic [7:0] key_code0;
    logic       key_ready0, tx_valid0, key_dropped0, busy0;
    logic [7:0] tx_data0;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_b [4];

    always #5 clk = ~clk;

    ansi_key_encoder #(.ESC_CODE(8'h1B), .DROP_UNMAPPED(1'b1)) u_drop (
        .clk(clk), .reset(reset), .keyValid(keyValid), .keyCode(keyCode),
        .keyReady(keyReady), .decckm(decckm), .lnm(lnm), .txReady(txReady),
        .txDataOutValid(txDataOutValid), .txDataOut(txDataOut),
        .keyDropped(keyDropped), .busy(busy)
    );

    ansi_key_encoder #(.ESC_CODE(8'h1B), .DROP_UNMAPPED(1'b0)) u_raw (
        .clk(clk), .reset(reset), .keyValid(key_valid0), .keyCode(key_code0),
        .keyReady(key_ready0), .decckm(1'b0), .lnm(1'b0), .txReady(tx_ready0),
        .txDataOutValid(tx_valid0), .txDataOut(tx_data0),
        .keyDropped(key_dropped0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: expected byte list for a key; returns 0 when the key is dropped.
    function automatic int model(input logic [7:0] code, input bit dk, input bit ln);
        logic [7:0] arrows [6];
        logic [7:0] tilde  [4];
        int k;
        arrows = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h46};
        tilde  = '{8'h32, 8'h33, 8'h35, 8'h36};
        k = int'(code);
        if (k < 128) begin
            exp_b[0] = code;
            if (k == 13 && ln) begin exp_b[1] = 8'h0A; return 2; end
            return 1;
        end else if (k <= 133) begin
            exp_b[0] = 8'h1B; exp_b[1] = dk ? 8'h4F : 8'h5B; exp_b[2] = arrows[k - 128];
            return 3;
        end else if (k <= 137) begin
            exp_b[0] = 8'h1B; exp_b[1] = 8'h5B; exp_b[2] = tilde[k - 134]; exp_b[3] = 8'h7E;
            return 4;
        end else if (k <= 141) begin
            exp_b[0] = 8'h1B; exp_b[1] = 8'h4F; exp_b[2] = 8'(8'h50 + (k - 138));
            return 3;
        end
        return 0;
    endfunction

    // Offers one key at a negedge and drains its bytes; pat gives txReady per
    // cycle (bit 0 first) when plen > 0, otherwise txReady is random.
    task automatic run_key(input logic [7:0] code, input bit dk, input bit ln,
                           input logic [15:0] pat, input int plen);
        int n, idx, cyc;
        bit tr;
        @(negedge clk);
        chk("key_ready_idle", keyReady, 1'b1);
        keyValid = 1'b1; keyCode = code; decckm = dk; lnm = ln;
        n = model(code, dk, ln);
        @(negedge clk);
        keyValid = 1'b0; keyCode = 8'($urandom);
        if (n == 0) begin
            chk("drop_no_valid", txDataOutValid, 1'b0);
            chk("drop_pulse", keyDropped, 1'b1);
            chk("drop_not_busy", busy, 1'b0);
            @(negedge clk);
            chk("drop_pulse_end", keyDropped, 1'b0);
            chk("drop_ready", keyReady, 1'b1);
            chk("drop_still_no_valid", txDataOutValid, 1'b0);
            $display("key %h dk=%0d lnm=%0d -> dropped", code, dk, ln);
            return;
        end
        idx = 0; cyc = 0;
        while (idx < n && cyc < 64) begin
            chk("byte_valid", txDataOutValid, 1'b1);
            chk($sformatf("byte%0d_of_%h", idx, code), txDataOut, exp_b[idx]);
            chk("busy_in_send", busy, 1'b1);
            chk("ready_low_in_send", keyReady, 1'b0);
            chk("no_drop_in_send", keyDropped, 1'b0);
            if (plen > 0) tr = (cyc < plen) ? pat[cyc[3:0]] : 1'b1;
            else          tr = 1'($urandom_range(0, 1));
            txReady = tr;
            decckm  = 1'($urandom);
            lnm     = 1'($urandom);
            if (tr && idx == n - 1) keyValid = 1'b0;
            else begin keyValid = 1'($urandom); keyCode = 8'($urandom); end
            @(negedge clk);
            if (tr) idx++;
            cyc++;
        end
        keyValid = 1'b0; txReady = 1'b0;
        chk("seq_complete", 8'(idx == n), 8'd1);
        chk("valid_after_seq", txDataOutValid, 1'b0);
        chk("busy_after_seq", busy, 1'b0);
        chk("ready_after_seq", keyReady, 1'b1);
        if (plen > 0) chk("pattern_cycles", 8'(cyc), 8'(plen));
        $display("key %h dk=%0d lnm=%0d -> %0d bytes in %0d cycles", code, dk, ln, n, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; keyValid = 1'b0; keyCode = 8'h00; decckm = 1'b0; lnm = 1'b0; txReady = 1'b0;
        key_valid0 = 1'b0; key_code0 = 8'h00; tx_ready0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", txDataOutValid, 1'b0);
        chk("rst_data", txDataOut, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dropped", keyDropped, 1'b0);
        chk("rst_key_ready", keyReady, 1'b0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", keyReady, 1'b1);
        $display("reset released");

        run_key(8'h41, 1'b0, 1'b0, 16'h0, 0);
        run_key(8'h80, 1'b0, 1'b0, 16'hFFFF, 3);
        run_key(8'h80, 1'b1, 1'b0, 16'hFFFF, 3);
        run_key(8'h87, 1'b0, 1'b0, 16'b1011001, 7);
        run_key(8'h0D, 1'b0, 1'b1, 16'hFFFF, 2);
        run_key(8'h0D, 1'b0, 1'b0, 16'hFFFF, 1);
        run_key(8'hF0, 1'b0, 1'b0, 16'h0, 0);
        run_key(8'h7F, 1'b0, 1'b0, 16'h0, 0);
        run_key(8'h8E, 1'b0, 1'b0, 16'h0, 0);

        // Raw variant passes unmapped codes through as one byte.
        @(negedge clk);
        key_valid0 = 1'b1; key_code0 = 8'hF0; tx_ready0 = 1'b1;
        @(negedge clk);
        key_valid0 = 1'b0;
        chk("raw_f0_valid", tx_valid0, 1'b1);
        chk("raw_f0_data", tx_data0, 8'hF0);
        chk("raw_f0_no_drop", key_dropped0, 1'b0);
        @(negedge clk);
        chk("raw_f0_done", tx_valid0, 1'b0);
        chk("raw_f0_ready", key_ready0, 1'b1);
        chk("raw_f0_idle", busy0, 1'b0);
        $display("raw variant key f0 -> 1 byte");

        // Reset with F1 half-sent: the pending 50 must never appear.
        @(negedge clk);
        keyValid = 1'b1; keyCode = 8'h8A; txReady = 1'b1;
        @(negedge clk);
        keyValid = 1'b0;
        chk("f1_b0", txDataOut, 8'h1B);
        @(negedge clk);
        chk("f1_b1", txDataOut, 8'h4F);
        @(negedge clk);
        chk("f1_b2_pending", txDataOut, 8'h50);
        reset = 1'b1; txReady = 1'b0;
        #1;
        chk("ready_low_in_reset", keyReady, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_valid", txDataOutValid, 1'b0);
        chk("midrst_data", txDataOut, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_dropped", keyDropped, 1'b0);
        #1;
        chk("midrst_ready", keyReady, 1'b1);
        $display("mid-sequence reset applied");
        run_key(8'h42, 1'b0, 1'b0, 16'h0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] code;
            if ($urandom_range(0, 1) == 1) code = 8'($urandom_range(8'h80, 8'h8F));
            else                           code = 8'($urandom);
            if ($urandom_range(0, 3) == 0) code = 8'h0D;
            run_key(code, 1'($urandom), 1'($urandom), 16'h0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
